// File: rtl/mul_div_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The master drives the request side; the slave returns busy/done and HI/LO.
interface mul_div_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        abort;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, abort, mthi, mtlo,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort, mthi, mtlo,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO registers: one radix-2 step per cycle,
// magnitude datapath with sign correction in a final FIX cycle.
module mul_div_unit (
    input  logic      i_clk,
    input  logic      i_rst,
    mul_div_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_md;
    logic [31:0] r_rem;
    logic [31:0] r_q;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_signed;
    logic        w_start_signed;
    logic [32:0] w_add;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_prod;
    logic [63:0] w_prod_s;
    logic [31:0] w_quo;
    logic [31:0] w_rmd;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    function automatic logic [31:0] f_mag(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    assign w_start_signed = ~bus.op[0];

    // Iteration step and final sign-corrected result. For MUL r_md is the multiplicand
    // and r_q the shifting multiplier; for DIV r_md is the divisor and r_q the dividend/quotient.
    always_comb begin
        w_signed = ~r_op[0];
        w_add    = {1'b0, r_rem} + {1'b0, (r_q[0] ? r_md : 32'd0)};
        w_shift  = {r_rem, r_q[31]};
        w_ge     = (w_shift >= {1'b0, r_md});
        w_sub    = w_shift[31:0] - r_md;
        w_prod   = {r_rem, r_q};
        w_prod_s = (w_signed && (r_a[31] ^ r_b[31])) ? (64'd0 - w_prod) : w_prod;
        w_quo    = (w_signed && (r_a[31] ^ r_b[31])) ? (32'd0 - r_q) : r_q;
        w_rmd    = (w_signed && r_a[31]) ? (32'd0 - r_rem) : r_rem;
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
        if (r_op[1]) begin
            if (r_b == 32'd0) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rmd;
                w_res_lo = w_quo;
            end
        end else begin
            w_res_hi = w_prod_s[63:32];
            w_res_lo = w_prod_s[31:0];
        end
    end

    // Control FSM, iteration registers and HI/LO; FIN behaves as IDLE for new requests.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_op    <= 2'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_md    <= 32'd0;
            r_rem   <= 32'd0;
            r_q     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    r_state <= ST_IDLE;
                    if (bus.abort) begin
                        r_busy <= 1'b0;
                    end else if (bus.start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_cnt   <= 5'd31;
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_rem   <= 32'd0;
                        if (bus.op[1]) begin
                            r_q  <= f_mag(bus.a, w_start_signed);
                            r_md <= f_mag(bus.b, w_start_signed);
                        end else begin
                            r_q  <= f_mag(bus.b, w_start_signed);
                            r_md <= f_mag(bus.a, w_start_signed);
                        end
                    end else begin
                        if (bus.mthi) r_hi <= bus.a;
                        if (bus.mtlo) r_lo <= bus.a;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        if (r_op[1]) begin
                            r_rem <= w_ge ? w_sub : w_shift[31:0];
                            r_q   <= {r_q[30:0], w_ge};
                        end else begin
                            r_rem <= w_add[32:1];
                            r_q   <= {w_add[0], r_q[31:1]};
                        end
                        if (r_cnt == 5'd0) begin
                            r_state <= ST_FIX;
                        end else begin
                            r_cnt <= r_cnt - 5'd1;
                        end
                    end
                end
                ST_FIX: begin
                    r_state <= bus.abort ? ST_IDLE : ST_FIN;
                    r_busy  <= 1'b0;
                    if (!bus.abort) begin
                        r_hi   <= w_res_hi;
                        r_lo   <= w_res_lo;
                        r_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO pushed at Start, popped on each Done pulse.
module tb_mul_div_unit;
    logic clk;
    logic rst;
    mul_div_if u_if();

    mul_div_unit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (u_if.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] sb_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model returning {HI,LO}
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] qa, qb, qq, qr;
        case (op)
            2'b00: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                return sa * sb;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                qa = a; qb = b;
                qq = qa / qb;
                qr = qa % qb;
                return {qr, qq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Scoreboard: each Done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (u_if.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("unexp_done", 64'd1, 64'd0);
            end else begin
                check_eq("hilo", {u_if.hi, u_if.lo}, sb_q.pop_front());
            end
        end
    end

    // Starts an op in the current cycle and returns in its Done cycle
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp);
        int cnt;
        int early;
        u_if.start = 1'b1;
        u_if.op    = op;
        u_if.a     = a;
        u_if.b     = b;
        sb_q.push_back(exp);
        tick();
        u_if.start = 1'b0;
        u_if.a     = $urandom;
        u_if.b     = $urandom;
        cnt   = 0;
        early = 0;
        while (u_if.busy === 1'b1 && cnt < 40) begin
            if (u_if.done === 1'b1) early++;
            tick();
            cnt++;
        end
        check_eq("busy_len", 64'(cnt), 64'd33);
        check_eq("done_early", 64'(early), 64'd0);
        check_eq("done_pulse", {63'd0, u_if.done}, 64'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] hi_save;

        rst = 1'b1;
        u_if.start = 1'b0; u_if.op = 2'b00; u_if.a = 32'd0; u_if.b = 32'd0;
        u_if.abort = 1'b0; u_if.mthi = 1'b0; u_if.mtlo = 1'b0;
        #1;
        check_eq("rst_out", {62'd0, u_if.busy, u_if.done}, 64'd0);
        check_eq("rst_hilo", {u_if.hi, u_if.lo}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7,        {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
        do_op(2'b11, 32'h0000_1234, 32'd0,        {32'h0000_1234, 32'hFFFF_FFFF});
        do_op(2'b10, 32'hFFFF_FFFB, 32'd0,        {32'hFFFF_FFFB, 32'hFFFF_FFFF});
        do_op(2'b10, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
        for (int i = 0; i < 12; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
            do_op(op, a, b, model(op, a, b));
        end
        tick();
        check_eq("done_clear", {63'd0, u_if.done}, 64'd0);

        u_if.mtlo = 1'b1; u_if.a = 32'd5;
        tick();
        u_if.mtlo = 1'b0;
        check_eq("mtlo", {32'd0, u_if.lo}, 64'd5);
        u_if.mthi = 1'b1; u_if.a = 32'd9;
        tick();
        u_if.mthi = 1'b0;
        check_eq("mthi", {u_if.hi, u_if.lo}, {32'd9, 32'd5});
        u_if.mthi = 1'b1; u_if.mtlo = 1'b1; u_if.a = 32'h0000_0042;
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
        check_eq("abort_mt", {u_if.hi, u_if.lo}, {32'd9, 32'd5});
        tick();
        u_if.mthi = 1'b0; u_if.mtlo = 1'b0;
        check_eq("mt_both", {u_if.hi, u_if.lo}, {32'h42, 32'h42});
        u_if.mtlo = 1'b1; u_if.a = 32'd5;
        tick();
        u_if.mtlo = 1'b0;
        hi_save = u_if.hi;

        u_if.start = 1'b1; u_if.abort = 1'b1; u_if.op = 2'b01; u_if.a = 32'd3; u_if.b = 32'd4;
        tick();
        u_if.start = 1'b0; u_if.abort = 1'b0;
        check_eq("abort_start", {63'd0, u_if.busy}, 64'd0);

        u_if.start = 1'b1; u_if.mthi = 1'b1; u_if.op = 2'b01; u_if.a = 32'd3; u_if.b = 32'd4;
        tick();
        u_if.start = 1'b0; u_if.mthi = 1'b0;
        check_eq("start_wins", {u_if.hi, 31'd0, u_if.busy}, {hi_save, 32'd1});
        repeat (3) tick();
        u_if.start = 1'b1; u_if.mtlo = 1'b1; u_if.a = 32'd77;
        tick();
        u_if.start = 1'b0; u_if.mtlo = 1'b0;
        check_eq("mt_busy", {32'd0, u_if.lo}, 64'd5);
        repeat (4) tick();
        u_if.abort = 1'b1;
        tick();
        u_if.abort = 1'b0;
        check_eq("abort_busy", {63'd0, u_if.busy}, 64'd0);
        repeat (40) tick();
        check_eq("abort_hilo", {u_if.hi, u_if.lo}, {hi_save, 32'd5});
        check_eq("abort_idle", {63'd0, u_if.busy}, 64'd0);

        u_if.start = 1'b1; u_if.op = 2'b11; u_if.a = 32'd1000; u_if.b = 32'd3;
        tick();
        u_if.start = 1'b0;
        repeat (19) tick();
        rst = 1'b1;
        #1;
        check_eq("rst_mid_out", {62'd0, u_if.busy, u_if.done}, 64'd0);
        check_eq("rst_mid_hilo", {u_if.hi, u_if.lo}, 64'd0);
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check_eq("rst_idle", {63'd0, u_if.busy}, 64'd0);
        do_op(2'b11, 32'd100, 32'd7, {32'd2, 32'd14});
        tick();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
